// File: rtl/lfsr_period_meter.sv
// Measures the period of an observed LFSR stream: captures a seed, counts valid
// samples until the seed recurs, and reports period plus stuck/timeout flags.
module lfsr_period_meter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   period,
    output logic             stuck,
    output logic             timeout
);

    localparam int unsigned CNT_W = WIDTH + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(1) << WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] seed, seed_d;
    logic [CNT_W-1:0] count, count_d;
    logic [CNT_W-1:0] period_d;
    logic             stuck_d, timeout_d, busy_d, done_d;
    logic [CNT_W-1:0] count_inc;
    logic             match;

    assign count_inc = count + CNT_W'(1);
    assign match     = (sample == seed);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; start re-arms from any state
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (start) state_d = ARM;
            ARM: begin
                if (start)             state_d = ARM;
                else if (sample_valid) state_d = COUNT;
            end
            COUNT: begin
                if (start)
                    state_d = ARM;
                else if (sample_valid && (match || count_inc == LIMIT))
                    state_d = DONE;
            end
            DONE:  state_d = start ? ARM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; busy/done follow the next state so they
    // line up with the registered state
    always_comb begin
        seed_d    = seed;
        count_d   = count;
        period_d  = period;
        stuck_d   = stuck;
        timeout_d = timeout;
        if (start) begin
            seed_d    = '0;
            count_d   = '0;
            period_d  = '0;
            stuck_d   = 1'b0;
            timeout_d = 1'b0;
        end else if (sample_valid) begin
            case (state)
                ARM: begin
                    seed_d  = sample;
                    count_d = '0;
                end
                COUNT: begin
                    // Match takes priority so a full-length period is reportable
                    if (match) begin
                        period_d = count_inc;
                        stuck_d  = (count_inc == CNT_W'(1));
                    end else if (count_inc == LIMIT) begin
                        timeout_d = 1'b1;
                        period_d  = '0;
                    end else begin
                        count_d = count_inc;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == ARM) || (state_d == COUNT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seed    <= '0;
            count   <= '0;
            period  <= '0;
            stuck   <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            seed    <= seed_d;
            count   <= count_d;
            period  <= period_d;
            stuck   <= stuck_d;
            timeout <= timeout_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_lfsr_period_meter.sv
// Scoreboard bench for lfsr_period_meter: expected results are queued when the
// terminating sample is driven and checked whenever done pulses.
module tb_lfsr_period_meter;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sample_valid;
    logic [WIDTH-1:0] sample;
    logic             busy, done, stuck, timeout;
    logic [WIDTH:0]   period;

    typedef struct packed {
        logic [WIDTH:0] period;
        logic           stuck;
        logic           timeout;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   dones    = 0;

    lfsr_period_meter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .sample(sample), .busy(busy), .done(done), .period(period),
        .stuck(stuck), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            dones++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_done: got period=%0d stuck=%0b timeout=%0b, expected no done",
                         period, stuck, timeout);
            end else begin
                e = sb.pop_front();
                if ({period, stuck, timeout} !== {e.period, e.stuck, e.timeout}) begin
                    failures++;
                    $display("FAIL sb_result: got period=%0d stuck=%0b timeout=%0b, expected period=%0d stuck=%0b timeout=%0b",
                             period, stuck, timeout, e.period, e.stuck, e.timeout);
                end
            end
        end
    end

    // One clock with the given inputs; returns #1 after the edge
    task automatic step(input logic st, input logic v, input logic [WIDTH-1:0] d);
        start = st; sample_valid = v; sample = d;
        @(posedge clk); #1;
        start = 1'b0; sample_valid = 1'b0;
    endtask

    task automatic push(input int p, input logic s, input logic t);
        exp_t e;
        e.period = (WIDTH+1)'(p); e.stuck = s; e.timeout = t;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; sample_valid = 1'b0; sample = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, period, stuck, timeout} !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy=%0b done=%0b period=%0d stuck=%0b timeout=%0b, expected all 0",
                     busy, done, period, stuck, timeout);
        end
        rst = 1'b1;
        step(1'b0, 1'b0, '0);
    endtask

    task automatic test_normal_period();
        step(1'b1, 1'b0, '0);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL normal_busy: got %0b expected 1", busy); end
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL normal_early_done: got %0b expected 0", done); end
        push(3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h5A);
        checks++;
        if ({done, busy} !== 2'b10) begin failures++; $display("FAIL normal_done_latency: got done/busy=%b expected 10", {done, busy}); end
        step(1'b0, 1'b0, '0);
        checks++;
        if ({done, period} !== {1'b0, 9'd3}) begin
            failures++; $display("FAIL normal_hold: got done=%0b period=%0d expected done=0 period=3", done, period);
        end
    endtask

    task automatic test_zero_seed();
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 8'h00);
        push(1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h00);
        checks++;
        if ({done, busy, stuck} !== 3'b101) begin failures++; $display("FAIL zero_seed_flags: got done/busy/stuck=%b expected 101", {done, busy, stuck}); end
        step(1'b0, 1'b0, '0);
    endtask

    task automatic test_timeout();
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 8'h01);
        for (int i = 0; i < 255; i++) step(1'b0, 1'b1, 8'h02);
        checks++;
        if ({done, busy} !== 2'b01) begin failures++; $display("FAIL timeout_early: got done/busy=%b expected 01", {done, busy}); end
        push(0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h02);
        checks++;
        if ({done, timeout, period} !== {2'b11, 9'd0}) begin
            failures++; $display("FAIL timeout_done: got done=%0b timeout=%0b period=%0d expected 1 1 0", done, timeout, period);
        end
        step(1'b0, 1'b0, '0);
    endtask

    task automatic test_gaps_restart();
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 8'hA5);
        push(2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'h20);
        step(1'b1, 1'b1, 8'h10);
        checks++;
        if ({busy, period} !== {1'b1, 9'd0}) begin
            failures++; $display("FAIL restart_clear: got busy=%0b period=%0d expected busy=1 period=0", busy, period);
        end
        step(1'b0, 1'b1, 8'h40);
        step(1'b0, 1'b1, 8'h10);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL restart_old_seed: got done=%0b expected 0", done); end
        step(1'b0, 1'b1, 8'h50);
        push(3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h40);
        step(1'b0, 1'b0, '0);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 8'h33);
        step(1'b0, 1'b1, 8'h44);
        rst = 1'b0;
        step(1'b0, 1'b1, 8'h33);
        rst = 1'b1;
        checks++;
        if ({busy, done, period, stuck, timeout} !== '0) begin
            failures++; $display("FAIL reset_mid: got busy=%0b done=%0b period=%0d expected all 0", busy, done, period);
        end
        step(1'b0, 1'b1, 8'h33);
        checks++;
        if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_mid_idle: got busy/done=%b expected 00", {busy, done}); end
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 8'h66);
        push(1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h66);
        step(1'b0, 1'b0, '0);
    endtask

    task automatic test_start_with_valid();
        step(1'b1, 1'b1, 8'h77);
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'h77);
        checks++;
        if ({done, busy} !== 2'b01) begin failures++; $display("FAIL idle_capture: got done/busy=%b expected 01", {done, busy}); end
        push(2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 8'h5A);
        push(1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h5A);
        step(1'b1, 1'b0, '0);
        checks++;
        if ({busy, done, period, stuck} !== {2'b10, 9'd0, 1'b0}) begin
            failures++; $display("FAIL done_start: got busy=%0b done=%0b period=%0d stuck=%0b expected 1 0 0 0", busy, done, period, stuck);
        end
        step(1'b0, 1'b1, 8'h12);
        step(1'b0, 1'b1, 8'h34);
        push(2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h12);
        step(1'b0, 1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_normal_period();
        test_zero_seed();
        test_timeout();
        test_gaps_restart();
        test_reset_mid();
        test_start_with_valid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0 || dones != 9) begin
            failures++; $display("FAIL sb_drain: got pending=%0d dones=%0d expected pending=0 dones=9", sb.size(), dones);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
